// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS datapath: sequences PC/IR/RF/DM/CP0 writes,
// selects the write-back source, and enters/leaves the interrupt handler between instructions.
module mc_ctrl #(
    parameter bit INT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic [4:0] rs,
    input  logic       zero,
    input  logic       intreq,
    output logic       pcwr,
    output logic       irwr,
    output logic       rfwr,
    output logic       dmwr,
    output logic       cp0wr,
    output logic       exl_set,
    output logic       exl_clr,
    output logic [2:0] npcsel,
    output logic [2:0] wdsel,
    output logic [1:0] regdst,
    output logic       alusrc,
    output logic       extop,
    output logic [1:0] aluop,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        INTR   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        IN_ADDU, IN_SUBU, IN_ORI, IN_LUI, IN_LW, IN_SW, IN_BEQ,
        IN_J, IN_JAL, IN_MFC0, IN_MTC0, IN_ERET, IN_NOP
    } instr_t;

    localparam logic [2:0] NPC_PC4 = 3'b000, NPC_BR = 3'b001, NPC_JMP = 3'b010,
                           NPC_EPC = 3'b011, NPC_HDL = 3'b100;
    localparam logic [2:0] WD_ALU = 3'b000, WD_DM = 3'b001, WD_PC4 = 3'b010, WD_CP0 = 3'b100;

    state_t state_q, state_d, end_next;
    instr_t instr;

    // Interrupts are only taken at an instruction boundary; eret never chains into one.
    assign end_next = (INT_EN && intreq) ? INTR : FETCH;
    assign state    = state_q;

    always_comb begin
        instr = IN_NOP;
        case (op)
            6'h00: begin
                if (funct == 6'h21)      instr = IN_ADDU;
                else if (funct == 6'h23) instr = IN_SUBU;
            end
            6'h0d: instr = IN_ORI;
            6'h0f: instr = IN_LUI;
            6'h23: instr = IN_LW;
            6'h2b: instr = IN_SW;
            6'h04: instr = IN_BEQ;
            6'h02: instr = IN_J;
            6'h03: instr = IN_JAL;
            6'h10: begin
                if (rs == 5'h00)                         instr = IN_MFC0;
                else if (rs == 5'h04)                    instr = IN_MTC0;
                else if (rs == 5'h10 && funct == 6'h18)  instr = IN_ERET;
            end
            default: instr = IN_NOP;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_d = FETCH;
        pcwr    = 1'b0;
        irwr    = 1'b0;
        rfwr    = 1'b0;
        dmwr    = 1'b0;
        cp0wr   = 1'b0;
        exl_set = 1'b0;
        exl_clr = 1'b0;
        npcsel  = NPC_PC4;
        wdsel   = WD_ALU;
        regdst  = 2'b00;
        alusrc  = 1'b0;
        extop   = 1'b0;
        aluop   = 2'b00;
        case (state_q)
            FETCH: begin
                irwr    = 1'b1;
                pcwr    = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                case (instr)
                    IN_J: begin
                        pcwr    = 1'b1;
                        npcsel  = NPC_JMP;
                        state_d = end_next;
                    end
                    IN_JAL, IN_MFC0: state_d = WB;
                    IN_NOP:          state_d = FETCH;
                    default:         state_d = EXEC;
                endcase
            end
            EXEC: begin
                case (instr)
                    IN_ADDU: state_d = WB;
                    IN_SUBU: begin aluop = 2'b01; state_d = WB; end
                    IN_ORI:  begin aluop = 2'b10; alusrc = 1'b1; state_d = WB; end
                    IN_LUI:  begin aluop = 2'b11; alusrc = 1'b1; state_d = WB; end
                    IN_LW, IN_SW: begin
                        alusrc  = 1'b1;
                        extop   = 1'b1;
                        state_d = MEM;
                    end
                    IN_BEQ: begin
                        aluop   = 2'b01;
                        pcwr    = zero;
                        npcsel  = NPC_BR;
                        state_d = end_next;
                    end
                    IN_MTC0: begin cp0wr = 1'b1; state_d = end_next; end
                    IN_ERET: begin
                        pcwr    = 1'b1;
                        npcsel  = NPC_EPC;
                        exl_clr = 1'b1;
                        state_d = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                if (instr == IN_LW) begin
                    state_d = WB;
                end else if (instr == IN_SW) begin
                    dmwr    = 1'b1;
                    state_d = end_next;
                end
            end
            WB: begin
                state_d = end_next;
                case (instr)
                    IN_ADDU, IN_SUBU: begin rfwr = 1'b1; regdst = 2'b01; end
                    IN_ORI, IN_LUI:   rfwr = 1'b1;
                    IN_LW:            begin rfwr = 1'b1; wdsel = WD_DM; end
                    IN_MFC0:          begin rfwr = 1'b1; wdsel = WD_CP0; end
                    IN_JAL: begin
                        rfwr   = 1'b1;
                        regdst = 2'b10;
                        wdsel  = WD_PC4;
                        pcwr   = 1'b1;
                        npcsel = NPC_JMP;
                    end
                    default: state_d = FETCH;
                endcase
            end
            INTR: begin
                exl_set = 1'b1;
                pcwr    = 1'b1;
                npcsel  = NPC_HDL;
            end
            default: state_d = FETCH;
        endcase
        // Reset aborts the instruction in flight without any side effect in that cycle.
        if (rst) begin
            pcwr    = 1'b0;
            irwr    = 1'b0;
            rfwr    = 1'b0;
            dmwr    = 1'b0;
            cp0wr   = 1'b0;
            exl_set = 1'b0;
            exl_clr = 1'b0;
            npcsel  = NPC_PC4;
            wdsel   = WD_ALU;
            regdst  = 2'b00;
            aluop   = 2'b00;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle model checked against two instances
// (interrupts enabled and disabled), directed cases followed by randomized instruction streams.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr, irwr, rfwr, dmwr, cp0wr, exl_set, exl_clr;
        logic [2:0] npcsel, wdsel;
        logic [1:0] regdst;
        logic       alusrc, extop;
        logic [1:0] aluop;
    } vec_t;

    typedef enum int {
        K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
        K_J, K_JAL, K_MFC0, K_MTC0, K_ERET, K_NOP
    } kind_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic [4:0] rs = '0;
    logic       zero = 1'b0, intreq = 1'b0;

    logic       pcwr, irwr, rfwr, dmwr, cp0wr, exl_set, exl_clr, alusrc, extop;
    logic [2:0] npcsel, wdsel, state;
    logic [1:0] regdst, aluop;
    logic       pcwr_b, irwr_b, rfwr_b, dmwr_b, cp0wr_b, exl_set_b, exl_clr_b, alusrc_b, extop_b;
    logic [2:0] npcsel_b, wdsel_b, state_b;
    logic [1:0] regdst_b, aluop_b;

    vec_t obs1, obs0;
    int   total = 0;
    int   bad   = 0;
    bit   sync0 = 1'b1;

    mc_ctrl #(.INT_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .rs(rs), .zero(zero), .intreq(intreq),
        .pcwr(pcwr), .irwr(irwr), .rfwr(rfwr), .dmwr(dmwr), .cp0wr(cp0wr),
        .exl_set(exl_set), .exl_clr(exl_clr), .npcsel(npcsel), .wdsel(wdsel),
        .regdst(regdst), .alusrc(alusrc), .extop(extop), .aluop(aluop), .state(state)
    );

    mc_ctrl #(.INT_EN(1'b0)) u_dut_noint (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .rs(rs), .zero(zero), .intreq(intreq),
        .pcwr(pcwr_b), .irwr(irwr_b), .rfwr(rfwr_b), .dmwr(dmwr_b), .cp0wr(cp0wr_b),
        .exl_set(exl_set_b), .exl_clr(exl_clr_b), .npcsel(npcsel_b), .wdsel(wdsel_b),
        .regdst(regdst_b), .alusrc(alusrc_b), .extop(extop_b), .aluop(aluop_b), .state(state_b)
    );

    assign obs1 = {state, pcwr, irwr, rfwr, dmwr, cp0wr, exl_set, exl_clr,
                   npcsel, wdsel, regdst, alusrc, extop, aluop};
    assign obs0 = {state_b, pcwr_b, irwr_b, rfwr_b, dmwr_b, cp0wr_b, exl_set_b, exl_clr_b,
                   npcsel_b, wdsel_b, regdst_b, alusrc_b, extop_b, aluop_b};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    // Architectural cycle count of each instruction, from FETCH to its last state.
    function automatic int seq_len(input kind_t k);
        case (k)
            K_LW:                           return 5;
            K_ADDU, K_SUBU, K_ORI, K_LUI,
            K_SW:                           return 4;
            K_J, K_NOP:                     return 2;
            default:                        return 3;
        endcase
    endfunction

    function automatic logic [2:0] seq_state(input kind_t k, input int i);
        if (i < 2)  return 3'(i);
        if (i == 2) return (k == K_JAL || k == K_MFC0) ? 3'd4 : 3'd2;
        if (i == 3) return (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
        return 3'd4;
    endfunction

    function automatic void expect_at(input kind_t k, input logic [2:0] st, input logic z,
                                      output vec_t e, output vec_t m);
        bit alu_k, rtype;
        alu_k = k inside {K_ADDU, K_SUBU, K_ORI, K_LUI};
        rtype = k inside {K_ADDU, K_SUBU};
        e = '0;
        m = '0;
        e.st = st;
        m.st = 3'b111;
        {m.pcwr, m.irwr, m.rfwr, m.dmwr, m.cp0wr, m.exl_set, m.exl_clr} = 7'h7f;
        if (st == 3'd0) begin
            e.pcwr = 1'b1; e.irwr = 1'b1; m.npcsel = 3'b111;
        end else if (st == 3'd5) begin
            e.pcwr = 1'b1; e.exl_set = 1'b1; e.npcsel = 3'b100; m.npcsel = 3'b111;
        end else if (st == 3'd1) begin
            if (k == K_J) begin e.pcwr = 1'b1; e.npcsel = 3'b010; m.npcsel = 3'b111; end
        end else if (st == 3'd2) begin
            if (alu_k) begin
                m.aluop = 2'b11;
                e.aluop = (k == K_ADDU) ? 2'b00 : (k == K_SUBU) ? 2'b01 :
                          (k == K_ORI)  ? 2'b10 : 2'b11;
                if (rtype) m.alusrc = 1'b1;
                if (k == K_ORI) begin m.alusrc = 1'b1; e.alusrc = 1'b1; m.extop = 1'b1; end
            end
            if (k == K_LW || k == K_SW) begin
                m.aluop = 2'b11; m.alusrc = 1'b1; e.alusrc = 1'b1; m.extop = 1'b1; e.extop = 1'b1;
            end
            if (k == K_BEQ) begin
                m.aluop = 2'b11; e.aluop = 2'b01; m.alusrc = 1'b1;
                e.pcwr = z; e.npcsel = 3'b001; m.npcsel = 3'b111;
            end
            if (k == K_MTC0) e.cp0wr = 1'b1;
            if (k == K_ERET) begin
                e.pcwr = 1'b1; e.exl_clr = 1'b1; e.npcsel = 3'b011; m.npcsel = 3'b111;
            end
        end else if (st == 3'd3) begin
            if (k == K_SW) e.dmwr = 1'b1;
        end else if (st == 3'd4) begin
            e.rfwr = 1'b1; m.wdsel = 3'b111; m.regdst = 2'b11;
            if (rtype)     e.regdst = 2'b01;
            if (k == K_LW) e.wdsel  = 3'b001;
            if (k == K_MFC0) e.wdsel = 3'b100;
            if (k == K_JAL) begin
                e.regdst = 2'b10; e.wdsel = 3'b010;
                e.pcwr = 1'b1; e.npcsel = 3'b010; m.npcsel = 3'b111;
            end
        end
    endfunction

    // During reset every enable and the listed selects must read zero.
    function automatic void rst_vec(input logic [2:0] st, output vec_t e, output vec_t m);
        e = '0;
        e.st = st;
        m = '1;
        m.alusrc = 1'b0;
        m.extop  = 1'b0;
    endfunction

    task automatic check(input string tag, input vec_t obs, input vec_t exp, input vec_t msk);
        total++;
        assert ((obs & msk) === (exp & msk)) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h mask=%h", tag, obs, exp, msk);
        end
    endtask

    task automatic set_instr(input kind_t k);
        logic [5:0] nop_ops [5];
        nop_ops = '{6'h3f, 6'h08, 6'h05, 6'h20, 6'h0a};
        op    = 6'($urandom);
        funct = 6'($urandom);
        rs    = 5'($urandom);
        case (k)
            K_ADDU: begin op = 6'h00; funct = 6'h21; end
            K_SUBU: begin op = 6'h00; funct = 6'h23; end
            K_ORI:  op = 6'h0d;
            K_LUI:  op = 6'h0f;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2b;
            K_BEQ:  op = 6'h04;
            K_J:    op = 6'h02;
            K_JAL:  op = 6'h03;
            K_MFC0: begin op = 6'h10; rs = 5'h00; end
            K_MTC0: begin op = 6'h10; rs = 5'h04; end
            K_ERET: begin op = 6'h10; rs = 5'h10; funct = 6'h18; end
            default: op = nop_ops[$urandom_range(0, 4)];
        endcase
    endtask

    task automatic do_reset();
        vec_t e, m;
        rst    = 1'b1;
        intreq = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        #1;
        rst_vec(3'd0, e, m);
        check("reset_hold", obs1, e, m);
        rst   = 1'b0;
        sync0 = 1'b1;
    endtask

    // Entered just after a negedge with both instances in FETCH; irq[i] is the intreq level
    // seen at the edge that closes step i. abort_at >= 0 applies reset for 2 clk at that step.
    task automatic run_instr(input kind_t k, input logic z, input logic [4:0] irq, input int abort_at);
        vec_t e, m;
        int   n;
        n = seq_len(k);
        set_instr(k);
        zero = z;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                intreq = 1'b0;
                #1;
                rst_vec(seq_state(k, i), e, m);
                check("rst_mid_instr", obs1, e, m);
                @(posedge clk); @(negedge clk); #1;
                rst_vec(3'd0, e, m);
                check("rst_second_cycle", obs1, e, m);
                @(posedge clk); @(negedge clk);
                rst = 1'b0;
                sync0 = 1'b1;
                #1;
                expect_at(k, 3'd0, z, e, m);
                check("rst_release_fetch", obs1, e, m);
                return;
            end
            #1;
            expect_at(k, seq_state(k, i), z, e, m);
            check($sformatf("%s_step%0d", k.name(), i), obs1, e, m);
            if (sync0) check($sformatf("%s_step%0d_noint", k.name(), i), obs0, e, m);
            intreq = irq[i];
            @(posedge clk); @(negedge clk);
        end
        if (irq[n-1] && k != K_ERET && k != K_NOP) begin
            #1;
            expect_at(k, 3'd5, z, e, m);
            check($sformatf("%s_intr", k.name()), obs1, e, m);
            if (sync0) begin
                expect_at(k, 3'd0, z, e, m);
                check($sformatf("%s_noint_fetch", k.name()), obs0, e, m);
                sync0 = 1'b0;
            end
            intreq = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        intreq = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        run_instr(K_LW,   1'b0, 5'b00000, -1);
        run_instr(K_ADDU, 1'b0, 5'b00000, -1);
        run_instr(K_BEQ,  1'b1, 5'b00000, -1);
        run_instr(K_BEQ,  1'b0, 5'b00000, -1);
        run_instr(K_JAL,  1'b0, 5'b00000, -1);
        run_instr(K_SW,   1'b0, 5'b01100, -1);
        do_reset();
        run_instr(K_MFC0, 1'b0, 5'b00000, -1);
        run_instr(K_MTC0, 1'b0, 5'b00000, -1);
        run_instr(K_ERET, 1'b0, 5'b11111, -1);
        run_instr(K_NOP,  1'b0, 5'b00000, -1);
        run_instr(K_J,    1'b0, 5'b00010, -1);
        run_instr(K_LW,   1'b0, 5'b00000, 4);

        for (int r = 0; r < 80; r++) begin
            if (r % 16 == 0) do_reset();
            run_instr(kind_t'($urandom_range(0, 12)), 1'($urandom), 5'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
